hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It decides, every cycle, whether the PC, IF/ID and ID/EX/EX/MEM registers advance, hold or take a bubble. It covers load-use hazards, taken branches resolved in EX, and a multi-cycle data-memory handshake. It drives the `controlFlush` input of the ID/EX register and the write enables of PC and IF/ID, and it keeps stall/flush event counters and a sticky memory-timeout flag.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before `mem_timeout` sets.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `ifid_rs1`, `ifid_rs2` in 5 each: source registers of the instruction in ID.
- `idex_memRead` in 1: the instruction in EX is a load.
- `idex_rd` in 5: destination register of the instruction in EX.
- `branch_taken` in 1: the branch or jump in EX redirects the PC.
- `mem_req` in 1: the instruction in MEM accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `PCWrite` out 1: PC register load enable.
- `IFID_write` out 1: IF/ID load enable.
- `IFID_flush` out 1: IF/ID loads a NOP.
- `controlFlush` out 1: ID/EX zeroes its control fields.
- `pipe_hold` out 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `state` out 2: current FSM state.
- `stall_cnt` out CNT_W: count of load-use bubbles inserted.
- `flush_cnt` out CNT_W: count of branch redirects.
- `wait_cnt` out CNT_W: count of memory-wait cycles.
- `mem_timeout` out 1: sticky error flag.

## Operation
- FSM states:
  - RUN=0.
  - LU_STALL=1: one-cycle load-use bubble in progress.
  - MEM_WAIT=2: pipeline frozen on memory.
  - REDIRECT=3: first cycle after a taken branch.
- The outputs are combinational (Mealy) from state and inputs. Counters, `state` and `mem_timeout` are registered.
- Definitions:
  - `mem_stall = mem_req & ~mem_ready`.
  - `lu_hazard = idex_memRead & idex_rd!=0 & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2)`.
- Decisions are evaluated in priority order. The first match applies in any state other than reset.
  1. `mem_stall`: `PCWrite=0`, `IFID_write=0`, `pipe_hold=1`, no flushes. Next state is MEM_WAIT and `wait_cnt` increments. `branch_taken` and `lu_hazard` are ignored, because EX is frozen and they are re-evaluated when the stall releases.
  2. `branch_taken`: `PCWrite=1`, `IFID_flush=1`, `controlFlush=1`. Next state is REDIRECT and `flush_cnt` increments. A simultaneous `lu_hazard` is ignored, since the ID instruction is squashed.
  3. `lu_hazard` with state≠LU_STALL: `PCWrite=0`, `IFID_write=0`, `controlFlush=1`. Next state is LU_STALL and `stall_cnt` increments.
  4. Otherwise: `PCWrite=1`, `IFID_write=1`, all flush and hold outputs 0. Next state is RUN.
- LU_STALL never inserts a second bubble for the same instruction, even if `lu_hazard` is still visible.
- REDIRECT behaves exactly like RUN. It exists only for observability and returns to RUN unless a rule above fires.
- MEM_WAIT timer:
  - An internal counter counts consecutive MEM_WAIT cycles and clears on leaving MEM_WAIT.
  - It saturates at `MEM_TIMEOUT`.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout` sets and stays set until reset.
  - The pipeline stays frozen; there is no recovery.
- Counters saturate at all-ones and do not wrap.
- Register x0 never causes a hazard.

## Timing
- Reset (`rst=0` at a rising edge):
  - `state`=RUN, all counters 0, `mem_timeout`=0, internal timer 0.
  - While `rst=0` the combinational outputs are forced to `PCWrite=0`, `IFID_write=0`, `IFID_flush=1`, `controlFlush=1`, `pipe_hold=0`, so bubbles fill the pipe.
  - Reset asserted in the middle of MEM_WAIT or LU_STALL aborts the stall at that edge.
- Load-use: exactly 1 bubble cycle. The consumer enters EX 2 cycles after the load, and forwarding from MEM/WB covers it.
- Taken branch: 2-cycle penalty, because the IF and ID instructions are squashed in the same cycle `branch_taken` is high.
- Memory wait: the freeze lasts exactly as many cycles as `mem_stall` is high. The first cycle with `mem_ready=1` advances normally with no extra bubble.
- `mem_ready=1` with `mem_req=0` is ignored.

## Test plan
- **Load-use:** `idex_memRead=1`, `idex_rd=5`, `ifid_rs2=5` -> for one cycle `PCWrite=0`, `IFID_write=0`, `controlFlush=1`, `state`=1 next; the following cycle is a normal advance; `stall_cnt`=1.
- **x0 and no-hazard:** `idex_rd=0` with `ifid_rs1=0`, then a load with `idex_rd=7` and sources 3/4 -> no stall, `stall_cnt` stays 0.
- **Branch vs load-use:** `branch_taken=1` and `lu_hazard` in the same cycle -> `IFID_flush=1`, `controlFlush=1`, `PCWrite=1`; `flush_cnt`=1, `stall_cnt`=0, `state`=3 next.
- **Memory wait with pending branch:** `mem_req=1`, `mem_ready=0` for 3 cycles while `branch_taken=1` -> `pipe_hold=1` and no flush for 3 cycles, `wait_cnt`=3; the branch flush occurs on the cycle `mem_ready=1`.
- **Timeout:** `MEM_TIMEOUT=4`, `mem_stall` held 10 cycles -> `mem_timeout` rises after the 4th MEM_WAIT cycle, stays 1 after `mem_ready`, and clears only on reset.
- **Reset mid-stall:** assert `rst=0` during MEM_WAIT with `wait_cnt`=2 -> the next edge gives `state`=0 and all counters 0; outputs are forced to the flush pattern while `rst=0`.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing for the 5-stage core: load-use bubbles, EX branch redirects, data-memory freeze.
// Enables and flushes are combinational from state and inputs; the pipeline holds while memory is not ready.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             controlFlush,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam int TMR_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

  state_t           state_q, state_nxt;
  logic [TMR_W-1:0] tmr_q, tmr_nxt;
  logic             mem_stall, lu_hazard;
  logic             stall_inc, flush_inc, wait_inc;

  assign state     = state_q;
  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hazard = idex_memRead & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  always_comb begin
    PCWrite      = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    controlFlush = 1'b0;
    pipe_hold    = 1'b0;
    state_nxt    = RUN;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    wait_inc     = 1'b0;
    if (!rst) begin
      // bubbles flow into the pipe while reset is held
      PCWrite      = 1'b0;
      IFID_write   = 1'b0;
      IFID_flush   = 1'b1;
      controlFlush = 1'b1;
    end else if (mem_stall) begin
      PCWrite    = 1'b0;
      IFID_write = 1'b0;
      pipe_hold  = 1'b1;
      state_nxt  = MEM_WAIT;
      wait_inc   = 1'b1;
    end else if (branch_taken) begin
      IFID_flush   = 1'b1;
      controlFlush = 1'b1;
      state_nxt    = REDIRECT;
      flush_inc    = 1'b1;
    end else if (lu_hazard && state_q != LU_STALL) begin
      PCWrite      = 1'b0;
      IFID_write   = 1'b0;
      controlFlush = 1'b1;
      state_nxt    = LU_STALL;
      stall_inc    = 1'b1;
    end
    tmr_nxt = '0;
    if (wait_inc) tmr_nxt = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      tmr_q       <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (wait_inc  && wait_cnt  != '1) wait_cnt  <= wait_cnt  + CNT_W'(1);
      // sticky: only reset clears it
      if (wait_inc && tmr_nxt == TMR_MAX) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations, then random stimulus vs a reference model.
module tb_hazard_stall_ctrl;
  localparam int TMO  = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
  logic          idex_memRead, branch_taken, mem_req, mem_ready;
  logic          PCWrite, IFID_write, IFID_flush, controlFlush, pipe_hold, mem_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_memRead(idex_memRead), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
    .controlFlush(controlFlush), .pipe_hold(pipe_hold), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
    .mem_timeout(mem_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: what the spec says the registered state should be
  int m_state, m_stall, m_flush, m_wait, m_run;
  bit m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lu();
    return idex_memRead && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic compare_all();
    bit [4:0] e; // {PCWrite, IFID_write, IFID_flush, controlFlush, pipe_hold}
    if (!rst)                          e = 5'b00110;
    else if (mem_req && !mem_ready)    e = 5'b00001;
    else if (branch_taken)             e = 5'b11110;
    else if (lu() && m_state != 1)     e = 5'b00010;
    else                               e = 5'b11000;
    chk("PCWrite",      PCWrite,      e[4]);
    chk("IFID_write",   IFID_write,   e[3]);
    chk("IFID_flush",   IFID_flush,   e[2]);
    chk("controlFlush", controlFlush, e[1]);
    chk("pipe_hold",    pipe_hold,    e[0]);
    chk("state",        state,        m_state);
    chk("stall_cnt",    stall_cnt,    m_stall);
    chk("flush_cnt",    flush_cnt,    m_flush);
    chk("wait_cnt",     wait_cnt,     m_wait);
    chk("mem_timeout",  mem_timeout,  m_to);
  endtask

  task automatic model_update();
    if (!rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0; m_to = 0;
    end else if (mem_req && !mem_ready) begin
      m_state = 2;
      m_wait  = sat(m_wait);
      m_run   = (m_run < TMO) ? m_run + 1 : TMO;
      if (m_run == TMO) m_to = 1;
    end else begin
      m_run = 0;
      if (branch_taken) begin
        m_state = 3; m_flush = sat(m_flush);
      end else if (lu() && m_state != 1) begin
        m_state = 1; m_stall = sat(m_stall);
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
    idex_memRead = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    model_update();
    @(negedge clk);
    step();
    #1;
    chk("rst_state", state, 0);
    chk("rst_ifid_flush", IFID_flush, 1);
    chk("rst_pcwrite", PCWrite, 0);
    rst = 1'b1;

    // load-use: single bubble even with hazard still visible
    idex_memRead = 1; idex_rd = 5; ifid_rs1 = 1; ifid_rs2 = 5;
    #1;
    chk("lu_pcwrite", PCWrite, 0);
    chk("lu_ctrlflush", controlFlush, 1);
    step();
    chk("lu_state", state, 1);
    #1;
    chk("lu_advance", PCWrite, 1);
    step();
    idle();
    step();
    chk("lu_stall_cnt", stall_cnt, 1);

    // x0 and non-matching load
    do_reset();
    idex_memRead = 1; idex_rd = 0; ifid_rs1 = 0;
    #1;
    chk("x0_pcwrite", PCWrite, 1);
    step();
    idex_rd = 7; ifid_rs1 = 3; ifid_rs2 = 4;
    #1;
    chk("nohaz_pcwrite", PCWrite, 1);
    step();
    chk("nohaz_stall_cnt", stall_cnt, 0);

    // branch beats load-use
    do_reset();
    idex_memRead = 1; idex_rd = 5; ifid_rs1 = 5; branch_taken = 1;
    #1;
    chk("br_ifid_flush", IFID_flush, 1);
    chk("br_pcwrite", PCWrite, 1);
    step();
    idle();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);
    chk("br_state", state, 3);

    // memory wait hides a pending branch
    do_reset();
    branch_taken = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_hold", pipe_hold, 1);
      chk("mw_noflush", IFID_flush, 0);
      step();
    end
    chk("mw_wait_cnt", wait_cnt, 3);
    mem_ready = 1;
    #1;
    chk("mw_release_flush", IFID_flush, 1);
    chk("mw_release_hold", pipe_hold, 0);
    step();
    chk("mw_flush_cnt", flush_cnt, 1);
    idle();

    // timeout
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3) chk("to_before", mem_timeout, 0);
      if (i == 4) chk("to_set", mem_timeout, 1);
    end
    mem_ready = 1;
    step();
    step();
    chk("to_sticky", mem_timeout, 1);
    do_reset();
    chk("to_cleared", mem_timeout, 0);

    // reset in the middle of a memory wait
    mem_req = 1; mem_ready = 0;
    step();
    step();
    chk("rs_wait2", wait_cnt, 2);
    rst = 1'b0;
    #1;
    chk("rs_force_pcw", PCWrite, 0);
    chk("rs_force_cf", controlFlush, 1);
    chk("rs_force_hold", pipe_hold, 0);
    step();
    chk("rs_state", state, 0);
    chk("rs_wait0", wait_cnt, 0);
    idle();

    // random traffic; narrow register range makes hazards frequent
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(99) != 0);
      idex_memRead = 1'($urandom_range(1));
      idex_rd      = 5'($urandom_range(3));
      ifid_rs1     = 5'($urandom_range(3));
      ifid_rs2     = 5'($urandom_range(3));
      branch_taken = ($urandom_range(5) == 0);
      mem_req      = ($urandom_range(2) == 0);
      mem_ready    = 1'($urandom_range(1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
